fsm_interval_timer: RTL
=======================

Name: fsm_interval_timer

Overview:
- Timer that answers the display FSM's counter handshake.
- The FSM raises initCount and presents a target on countVal. This block counts prescaled ticks (seconds on the board clock) and returns a one-cycle contBETval pulse when count >= target.
- It then reloads automatically, so the FSM can chain intervals without dropping initCount: show A/B for 5 s, then the result for 2 s.
- It also exports the live count for the display.

Parameters:
- PRESCALE, 50000000, clock cycles per tick; legal range >= 1; 1 = one tick per clock.
- COUNT_W, 3, width of countVal, count and the latched target.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- initCount  in  1  high = FSM requests timing; low = abort/idle.
- countVal  in  COUNT_W  target tick count; sampled only at load.
- contBETval  out  1  registered; one-cycle pulse when count >= latched target.
- count  out  COUNT_W  registered ticks elapsed in the current interval.
- tick  out  1  registered; one-cycle pulse when the prescaler wraps.

Behaviour:
- Reset: on a rising clock edge with reset==0, all of the following are cleared: state=IDLE, prescaler=0, count=0, target=0, contBETval=0, tick=0. Reset overrides every other input.
- Prescaler width is the minimum needed to hold PRESCALE-1. count saturates at 2^COUNT_W-1. Comparison is unsigned.
- States: IDLE, RUN, DONE.
- IDLE, initCount==0: hold; count, prescaler and outputs stay 0.
- IDLE, initCount==1 ("load edge"): target<=countVal, count<=0, prescaler<=0, go to RUN.
- RUN, initCount==0: go to IDLE; clear count and prescaler; no pulse.
- RUN, count>=target: go to DONE; contBETval<=1. The compare has priority over the increment, so no further ticks are counted.
- RUN, otherwise: prescaler increments. When prescaler==PRESCALE-1 it wraps to 0, tick pulses for one cycle, and count increments.
- DONE: contBETval is high for exactly this one cycle. The FSM changes state on this edge.
  - Next edge with initCount==1: acts as a new load edge. countVal is re-sampled (the FSM has already switched it), count and prescaler clear, go to RUN, contBETval<=0.
  - Next edge with initCount==0: go to IDLE, contBETval<=0.
- Latency: from a load edge, contBETval is high in the cycle following edge N*PRESCALE+1, where N = latched target. N=0 gives a pulse after edge 1.
- Between load edge and pulse, contBETval stays 0. Pulses never occur on consecutive cycles.
- countVal changes during RUN are ignored until the next load.
- tick is 0 outside RUN.

Optional Feature:
- Macro: TIMER_PAUSE_EN.
- Defined: adds input port "hold" (1 bit). While hold==1 in RUN, prescaler, count and tick freeze, and the compare still runs. Any pulse is delayed by exactly the number of held RUN cycles. hold has no effect in IDLE or DONE. initCount==0 still aborts.
- Not defined: the hold port is absent and behaviour is as above.

Test Plan:
- Reset: PRESCALE=4; reset=0 for 2 edges with initCount=1, countVal=3 -> count=0, tick=0, contBETval=0, state IDLE. reset=1 -> load on the next edge.
- Basic interval: PRESCALE=4, countVal=2, initCount raised before edge E0 -> tick after E4 and E8; count=1 after E4, 2 after E8; contBETval=1 only in the cycle after E9.
- Chained reload: countVal=5 held, initCount held high; countVal set to 2 during the DONE cycle -> the reload latches 2; next pulse 9 edges after the DONE->RUN edge, with no intermediate pulse.
- Zero target: countVal=0, initCount held high -> contBETval pulses every 2nd cycle (RUN, DONE alternating); count stays 0; tick never fires.
- Abort: countVal=3, initCount dropped during RUN cycle 3 -> IDLE next edge, count=0, no pulse. Re-raise -> full 3*4+1 edge latency from the new load edge.
- TIMER_PAUSE_EN: countVal=2, hold=1 for 3 RUN cycles starting at RUN cycle 2 -> pulse after E12 instead of E9, and count does not change during hold.

Source files
------------

// File: rtl/fsm_interval_timer.sv
// Prescaled interval timer answering the display FSM's initCount/contBETval handshake.
// Optional TIMER_PAUSE_EN macro adds a hold input that freezes timing while in RUN.
module fsm_interval_timer #(
  parameter int PRESCALE = 50000000,
  parameter int COUNT_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               initCount,
  input  logic [COUNT_W-1:0] countVal,
`ifdef TIMER_PAUSE_EN
  input  logic               hold,
`endif
  output logic               contBETval,
  output logic [COUNT_W-1:0] count,
  output logic               tick
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PS_W-1:0]    pre_q, pre_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] tgt_q, tgt_d;
  logic               pulse_q, pulse_d;
  logic               tick_q, tick_d;

  logic hold_w;
  logic reached;
  logic wrap;
  logic in_run;
  logic clr;
  logic load;
  logic fire;
  logic adv;

`ifdef TIMER_PAUSE_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  assign reached = (cnt_q >= tgt_q);
  assign wrap    = (pre_q == PS_MAX);
  assign in_run  = (state_q == RUN);

  // Decoded edge actions; exactly one (or none, while held) is active.
  assign clr  = !initCount;
  assign load = initCount && (state_q != RUN);
  assign fire = initCount && in_run && reached;
  assign adv  = initCount && in_run && !reached && !hold_w;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (initCount) state_d = RUN;
      end
      RUN: begin
        if (!initCount)   state_d = IDLE;
        else if (reached) state_d = DONE;
      end
      DONE: begin
        state_d = initCount ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    pulse_d = 1'b0;
    tick_d  = 1'b0;
    unique case (1'b1)
      clr: begin
        pre_d = '0;
        cnt_d = '0;
      end
      load: begin
        tgt_d = countVal;
        pre_d = '0;
        cnt_d = '0;
      end
      fire: begin
        pulse_d = 1'b1;
      end
      adv: begin
        if (wrap) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      pulse_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      pulse_q <= pulse_d;
      tick_q  <= tick_d;
    end
  end

  assign contBETval = pulse_q;
  assign count      = cnt_q;
  assign tick       = tick_q;

endmodule
